// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver: FSM state encoding,
// default parameter values and a counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   localparam int DEFAULT_CLOCKS_PER_PULSE = 4;
   localparam int DEFAULT_W_OUT            = 16;
   localparam int DEFAULT_BITS_PER_WORD    = 8;

   // Bits needed for a counter running 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, samples each bit at mid-period, and packs
// NUM_WORDS characters (first arrival in slot 0) into one m_data word.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
   parameter int W_OUT            = DEFAULT_W_OUT,
   parameter int BITS_PER_WORD    = DEFAULT_BITS_PER_WORD
) (
   input  logic                                               clk,
   input  logic                                               rstn,
   input  logic                                               rx,
   output logic                                               m_valid,
   output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0]  m_data
);

   localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
   localparam int CNT_W     = cnt_width(CLOCKS_PER_PULSE);
   localparam int BIT_W     = cnt_width(BITS_PER_WORD);
   localparam int IDX_W     = cnt_width(NUM_WORDS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

   logic                                         rx_meta_q, rx_sync_q;
   state_e                                       state_q, state_d;
   logic [CNT_W-1:0]                             cnt_q, cnt_d;
   logic [BIT_W-1:0]                             bit_q, bit_d;
   logic [IDX_W-1:0]                             idx_q, idx_d;
   logic [BITS_PER_WORD-1:0]                     shift_q, shift_d;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]      words_q, words_d;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]      m_data_q, m_data_d;
   logic                                         m_valid_q, m_valid_d;
   logic [BITS_PER_WORD-1:0]                     sample;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         words_q   <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         words_q   <= words_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      words_d   = words_q;
      m_data_d  = m_data_q;
      m_valid_d = 1'b0;
      // New bit enters at the MSB so the first data bit ends up in bit 0.
      sample                  = shift_q >> 1;
      sample[BITS_PER_WORD-1] = rx_sync_q;

      case (state_q)
         IDLE: begin
            if (!rx_sync_q) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               if (!rx_sync_q) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = sample;
               if (bit_q == BIT_LAST) begin
                  state_d        = STOP;
                  words_d[idx_q] = sample;
                  idx_d          = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     m_data_d  = words_d;
                     m_valid_d = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Stop-bit level is ignored; just wait out one bit period.
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven word vectors, random words,
// start-bit glitch rejection and mid-character reset, with a scoreboard.
module tb_uart_rx;

   localparam int CPP = 4;

   typedef struct {
      logic [7:0]  c0;
      logic [7:0]  c1;
      int          pre_idle;
      logic [15:0] exp_word;
   } vec_t;

   logic            clk  = 1'b0;
   logic            rstn = 1'b1;
   logic            rx   = 1'b1;
   logic            m_valid;
   logic [1:0][7:0] m_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pulses = 0;
   int          n_sent   = 0;
   logic [15:0] exp_q[$];
   vec_t        vecs[5];

   always #5 clk = ~clk;

   uart_rx #(
      .CLOCKS_PER_PULSE(CPP),
      .W_OUT(16),
      .BITS_PER_WORD(8)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .rx(rx),
      .m_valid(m_valid),
      .m_data(m_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard / output monitor, sampling on the falling edge.
   initial begin
      logic        prev_valid;
      logic [15:0] last_data;
      logic [15:0] exp_w;
      prev_valid = 1'b0;
      last_data  = '0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            prev_valid = 1'b0;
            last_data  = m_data;
         end else begin
            if (prev_valid) check("pulse_width", {31'd0, m_valid}, 32'd0);
            if (m_valid) begin
               n_pulses++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %h, expected no pulse", m_data);
               end else begin
                  exp_w = exp_q.pop_front();
                  check("word", {16'd0, m_data}, {16'd0, exp_w});
                  $display("word %0d: m_data=%h expected=%h", n_pulses, m_data, exp_w);
               end
            end else begin
               check("stable", {16'd0, m_data}, {16'd0, last_data});
            end
            last_data  = m_data;
            prev_valid = m_valid;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic drive_bit(input logic b);
      repeat (CPP) begin
         @(negedge clk);
         rx = b;
      end
   endtask

   task automatic send_char(input logic [7:0] c, input int pre);
      idle(pre);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(c[i]);
      drive_bit(1'b1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      logic [7:0]  part;

      vecs[0] = '{8'hA5, 8'h3C, 5,  16'h3CA5};
      vecs[1] = '{8'h00, 8'hFF, 1,  16'hFF00};
      vecs[2] = '{8'hFF, 8'h00, 12, 16'h00FF};
      vecs[3] = '{8'h55, 8'hAA, 3,  16'hAA55};
      vecs[4] = '{8'h01, 8'h80, 20, 16'h8001};

      rx   = 1'b1;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_valid", {31'd0, m_valid}, 32'd0);
      check("reset_data", {16'd0, m_data}, 32'd0);
      rstn = 1'b0;
      idle(10);

      for (int v = 0; v < 5; v++) begin
         exp_q.push_back(vecs[v].exp_word);
         n_sent++;
         send_char(vecs[v].c0, vecs[v].pre_idle);
         send_char(vecs[v].c1, vecs[v].pre_idle);
         wait_drain();
         idle(50);
      end

      // One-cycle low in IDLE must be rejected as a glitch.
      idle(10);
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      idle(20);
      exp_q.push_back(16'hFF00);
      n_sent++;
      send_char(8'h00, 2);
      send_char(8'hFF, 2);
      wait_drain();
      idle(50);

      // Reset after start + 5 data bits of 0x34 discards the partial word.
      part = 8'h34;
      idle(5);
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(part[i]);
      @(negedge clk);
      rstn = 1'b1;
      rx   = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_valid", {31'd0, m_valid}, 32'd0);
      check("midreset_data", {16'd0, m_data}, 32'd0);
      @(negedge clk);
      rstn = 1'b0;
      idle(10);
      exp_q.push_back(16'h5678);
      n_sent++;
      send_char(8'h78, 3);
      send_char(8'h56, 3);
      wait_drain();
      idle(50);

      for (int k = 0; k < 10; k++) begin
         w = 16'($urandom);
         exp_q.push_back(w);
         n_sent++;
         idle(int'($urandom_range(1, 100)));
         send_char(w[7:0], int'($urandom_range(1, 20)));
         send_char(w[15:8], int'($urandom_range(1, 20)));
         wait_drain();
         idle(50);
      end

      check("pulse_count", n_pulses, n_sent);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
